// File: rtl/script_sequencer_pkg.sv
// rtl/script_sequencer_pkg.sv - shared opcodes, field constants and FSM encoding for the script sequencer
package script_sequencer_pkg;

    localparam logic [2:0] OP_ACTION = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_WAIT   = 3'b011;
    localparam logic [2:0] OP_END    = 3'b111;

    localparam logic [1:0] if_mode  = 2'b00;
    localparam logic [1:0] ifn_mode = 2'b01;

    localparam logic [2:0] player_ready   = 3'd0;
    localparam logic [2:0] player_hasitem = 3'd1;
    localparam logic [2:0] target_ready   = 3'd2;
    localparam logic [2:0] target_hasitem = 3'd3;

    localparam int FB_GAME_OVER = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_ADVANCE = 3'd4,
        S_HALT    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/script_sequencer_if.sv
// rtl/script_sequencer_if.sv - enable/ready handshake and decoded fields between sequencer and execution units
interface script_sequencer_if;
    logic       act_en;
    logic       act_ready;
    logic       jmp_en;
    logic       jmp_ready;
    logic [7:0] jmp_next_pc;
    logic       wait_en;
    logic       wait_ready;
    logic [7:0] i_num;
    logic [2:0] i_sign;
    logic [1:0] func;

    modport master (
        output act_en, jmp_en, wait_en, i_num, i_sign, func,
        input  act_ready, jmp_ready, wait_ready, jmp_next_pc
    );

    modport slave (
        input  act_en, jmp_en, wait_en, i_num, i_sign, func,
        output act_ready, jmp_ready, wait_ready, jmp_next_pc
    );
endinterface

// File: rtl/script_sequencer_unit_watchdog.sv
// rtl/script_sequencer_unit_watchdog.sv - counts enabled cycles of the active unit, flags minimum hold and timeout
module unit_watchdog #(
    parameter int MIN_EN_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic min_reached,
    output logic timeout
);

    logic [7:0] count;
    logic [8:0] cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // cycles includes the current enabled cycle, so the flags are usable in the same cycle
    assign cycles      = {1'b0, count} + 9'd1;
    assign min_reached = enable && (cycles >= 9'(MIN_EN_CYCLES));
    assign timeout     = enable && (cycles >= 9'(TIMEOUT));

endmodule

// File: rtl/script_sequencer.sv
// rtl/script_sequencer.sv - fetches, decodes and dispatches script instructions to action/jump/wait units
module script_sequencer
    import script_sequencer_pkg::*;
#(
    parameter int MIN_EN_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [7:0]          instr_addr,
    input  logic [15:0]         instr_data,
    input  logic [7:0]          feedback_sig,
    script_sequencer_if.master  units,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          pc
);

    seq_state_t state;
    logic [7:0] pc_q;
    logic [7:0] jmp_pc_q;
    logic [2:0] op_q;
    logic [2:0] opc;
    logic       sel_ready;
    logic       min_reached;
    logic       timeout;
    logic       unused_fb;

    assign opc        = instr_data[2:0];
    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign unused_fb  = ^feedback_sig[7:1];

    unit_watchdog #(
        .MIN_EN_CYCLES (MIN_EN_CYCLES),
        .TIMEOUT       (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .clear       (state != S_EXEC),
        .enable      (state == S_EXEC),
        .min_reached (min_reached),
        .timeout     (timeout)
    );

    // only the dispatched unit's ready is looked at
    always_comb begin
        sel_ready = 1'b0;
        case (op_q)
            OP_ACTION: sel_ready = units.act_ready;
            OP_JUMP:   sel_ready = units.jmp_ready;
            OP_WAIT:   sel_ready = units.wait_ready;
            default:   sel_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc_q          <= '0;
            jmp_pc_q      <= '0;
            op_q          <= '0;
            units.i_num   <= '0;
            units.i_sign  <= '0;
            units.func    <= '0;
            units.act_en  <= 1'b0;
            units.jmp_en  <= 1'b0;
            units.wait_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc_q  <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    units.i_num  <= instr_data[15:8];
                    units.i_sign <= instr_data[7:5];
                    units.func   <= instr_data[4:3];
                    op_q         <= opc;
                    if (opc == OP_END || feedback_sig[FB_GAME_OVER]) begin
                        state <= S_HALT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (opc == OP_ACTION) begin
                        state        <= S_EXEC;
                        units.act_en <= 1'b1;
                    end else if (opc == OP_JUMP) begin
                        state        <= S_EXEC;
                        units.jmp_en <= 1'b1;
                    end else if (opc == OP_WAIT) begin
                        state         <= S_EXEC;
                        units.wait_en <= 1'b1;
                    end else begin
                        state <= S_HALT;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // a result arriving on the timeout cycle still counts as success
                    if (min_reached && sel_ready) begin
                        state         <= S_ADVANCE;
                        units.act_en  <= 1'b0;
                        units.jmp_en  <= 1'b0;
                        units.wait_en <= 1'b0;
                        if (op_q == OP_JUMP) begin
                            jmp_pc_q <= units.jmp_next_pc;
                        end
                    end else if (timeout) begin
                        state         <= S_HALT;
                        units.act_en  <= 1'b0;
                        units.jmp_en  <= 1'b0;
                        units.wait_en <= 1'b0;
                        busy          <= 1'b0;
                        error         <= 1'b1;
                    end
                end
                S_ADVANCE: begin
                    state <= S_FETCH;
                    pc_q  <= (op_q == OP_JUMP) ? jmp_pc_q : pc_q + 8'd2;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
